fetch_stage: RTL



---
 rtl/fetch_stage.sv | 99 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, drives the instruction memory address,
// and buffers {pc, instr} pairs in a small FIFO toward decode with valid/ready.
// Redirects from execute flush the buffer and restart fetch at the new PC.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] fetch_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        StFetch,
        StFull
    } state_t;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_pc    [DEPTH];
    logic [31:0]   buf_instr [DEPTH];

    state_t state;
    logic   push;
    logic   pop;

    // Buffer occupancy decides whether fetch may proceed without a pop.
    always_comb begin
        state = (count == FULL_COUNT) ? StFull : StFetch;
    end

    // Handshake decode; a redirect suppresses both sides of the buffer.
    always_comb begin
        pop  = out_valid & out_ready & ~redirect_valid;
        // A pop in the same cycle frees the slot a FULL buffer needs.
        push = imem_valid & ~redirect_valid & ((state == StFetch) | pop);
    end

    // PC, pointers, occupancy, counter and buffer storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fetch_count <= '0;
            // Cleared so the head outputs are defined (zero) straight out of reset.
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (push) begin
                buf_pc[wr_ptr]    <= fetch_pc;
                buf_instr[wr_ptr] <= imem_data;
                wr_ptr            <= wr_ptr + 1'b1;
                fetch_pc          <= fetch_pc + 32'd4;
                fetch_count       <= fetch_count + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Outputs come straight from registers; no input reaches them combinationally.
    always_comb begin
        imem_addr = fetch_pc;
        out_valid = (count != '0);
        out_pc    = buf_pc[rd_ptr];
        out_instr = buf_instr[rd_ptr];
    end

endmodule
